// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 4-digit 7-segment scan controller with a one-deep frame buffer.
// New frames are double-buffered and only swapped in at frame boundaries.
module seg7_scan_ctrl #(
   parameter int unsigned ON_CYC    = 100000,
   parameter int unsigned BLANK_CYC = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_bcd,
   input  logic        lz_en,
   output logic [3:0]  DIGIT,
   output logic [6:0]  DISPLAY,
   output logic        frame_done
);

   localparam int unsigned CW = 20;
   localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYC - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

   typedef enum logic {S_ON, S_BLANK} state_e;

   state_e        state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          boundary;

   logic [15:0]   act_val_q, act_val_d;
   logic          act_lz_q, act_lz_d;
   logic [15:0]   pend_val_q, pend_val_d;
   logic          pend_lz_q, pend_lz_d;
   logic          pend_full_q, pend_full_d;

   logic [3:0]    digit_q, digit_d;
   logic [6:0]    display_q, display_d;
   logic          frame_done_q, frame_done_d;

   logic [3:0]    nib;
   logic [3:0]    sup;
   logic          accept, load;

   function automatic logic [6:0] seg_decode(input logic [3:0] n);
      case (n)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_ON;
         idx_q        <= 2'd0;
         cnt_q        <= '0;
         act_val_q    <= 16'h0000;
         act_lz_q     <= 1'b0;
         pend_val_q   <= 16'h0000;
         pend_lz_q    <= 1'b0;
         pend_full_q  <= 1'b0;
         digit_q      <= 4'b1111;
         display_q    <= 7'b1111111;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         act_val_q    <= act_val_d;
         act_lz_q     <= act_lz_d;
         pend_val_q   <= pend_val_d;
         pend_lz_q    <= pend_lz_d;
         pend_full_q  <= pend_full_d;
         digit_q      <= digit_d;
         display_q    <= display_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q + 20'd1;
      boundary = 1'b0;
      case (state_q)
         S_ON: begin
            if (cnt_q == ON_LAST) begin
               state_d = S_BLANK;
               cnt_d   = '0;
            end
         end
         S_BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               state_d  = S_ON;
               cnt_d    = '0;
               idx_d    = idx_q + 2'd1;
               boundary = (idx_q == 2'd3);
            end
         end
         default: begin
            state_d = S_ON;
            cnt_d   = '0;
         end
      endcase
   end

   // A boundary with a full buffer frees it, but an offer on that same edge
   // still sees in_ready=0 and waits one cycle.
   always_comb begin
      accept       = in_valid && !pend_full_q;
      load         = boundary && pend_full_q;
      act_val_d    = act_val_q;
      act_lz_d     = act_lz_q;
      pend_val_d   = pend_val_q;
      pend_lz_d    = pend_lz_q;
      pend_full_d  = pend_full_q;
      frame_done_d = boundary;
      if (load) begin
         act_val_d   = pend_val_q;
         act_lz_d    = pend_lz_q;
         pend_full_d = 1'b0;
      end else if (accept) begin
         pend_val_d  = in_bcd;
         pend_lz_d   = lz_en;
         pend_full_d = 1'b1;
      end
   end

   // Digit k is suppressed only when it and every higher digit are zero.
   always_comb begin
      sup[3] = act_lz_q && (act_val_q[15:12] == 4'd0);
      sup[2] = sup[3] && (act_val_q[11:8] == 4'd0);
      sup[1] = sup[2] && (act_val_q[7:4] == 4'd0);
      sup[0] = 1'b0;
      nib    = act_val_q[{idx_q, 2'b00} +: 4];
      digit_d   = 4'b1111;
      display_d = 7'b1111111;
      if (state_q == S_ON) begin
         digit_d   = ~(4'b0001 << idx_q);
         display_d = sup[idx_q] ? 7'b1111111 : seg_decode(nib);
      end
   end

   assign in_ready   = !pend_full_q;
   assign DIGIT      = digit_q;
   assign DISPLAY    = display_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with a 24-cycle frame (ON_CYC=4, BLANK_CYC=2).
// Each frame is walked cycle by cycle against hand-written segment patterns.
module tb_seg7_scan_ctrl;

   localparam logic [6:0] P0 = 7'b1000000;
   localparam logic [6:0] P1 = 7'b1111001;
   localparam logic [6:0] P2 = 7'b0100100;
   localparam logic [6:0] P3 = 7'b0110000;
   localparam logic [6:0] P4 = 7'b0011001;
   localparam logic [6:0] P5 = 7'b0010010;
   localparam logic [6:0] P6 = 7'b0000010;
   localparam logic [6:0] P7 = 7'b1111000;
   localparam logic [6:0] P8 = 7'b0000000;
   localparam logic [6:0] P9 = 7'b0010000;
   localparam logic [6:0] PD = 7'b0111111;
   localparam logic [6:0] PB = 7'b1111111;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, lz_en, frame_done;
   logic [15:0] in_bcd;
   logic [3:0]  DIGIT;
   logic [6:0]  DISPLAY;

   int          errors = 0;
   int          checks = 0;
   logic [16:0] offq[$];
   logic        prod_en  = 1'b0;
   logic        exp_pend = 1'b0;

   always #5 clk = ~clk;

   seg7_scan_ctrl #(.ON_CYC(4), .BLANK_CYC(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_bcd     (in_bcd),
      .lz_en      (lz_en),
      .DIGIT      (DIGIT),
      .DISPLAY    (DISPLAY),
      .frame_done (frame_done)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      if (prod_en && offq.size() != 0) begin
         in_valid = 1'b1;
         {lz_en, in_bcd} = offq[0];
      end else begin
         in_valid = 1'b0;
      end
   endtask

   // Producer holds its offer until a handshake; exp_pend tracks the buffer.
   task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input int push_c, input int n_cyc);
      logic [6:0] segs [4];
      logic       acc;
      logic [3:0] ed;
      logic [6:0] es;
      segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
      for (int c = 0; c < n_cyc; c++) begin
         if (c == push_c) prod_en = 1'b1;
         drive();
         acc = in_valid && !exp_pend;
         @(posedge clk); #1;
         if (c == 23 && exp_pend) begin
            exp_pend = 1'b0;
         end else if (acc) begin
            exp_pend = 1'b1;
            void'(offq.pop_front());
         end
         if ((c % 6) < 4) begin
            ed = ~(4'b0001 << (c / 6));
            es = segs[c / 6];
         end else begin
            ed = 4'b1111;
            es = PB;
         end
         chk($sformatf("%s c%0d DIGIT", tag, c), {12'h0, DIGIT}, {12'h0, ed});
         chk($sformatf("%s c%0d DISPLAY", tag, c), {9'h0, DISPLAY}, {9'h0, es});
         chk($sformatf("%s c%0d frame_done", tag, c), {15'h0, frame_done}, {15'h0, (c == 23)});
         chk($sformatf("%s c%0d in_ready", tag, c), {15'h0, in_ready}, {15'h0, !exp_pend});
      end
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_bcd   = 16'h0000;
      lz_en    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset DIGIT", {12'h0, DIGIT}, 16'h000F);
      chk("reset DISPLAY", {9'h0, DISPLAY}, 16'h007F);
      chk("reset frame_done", {15'h0, frame_done}, 16'h0000);
      chk("reset in_ready", {15'h0, in_ready}, 16'h0001);
      reset = 1'b0;

      // 1234 accepted mid-frame; current frame keeps showing 0000.
      offq.push_back({1'b0, 16'h1234}); prod_en = 1'b0;
      check_frame("F1", P0, P0, P0, P0, 8, 24);
      offq.push_back({1'b1, 16'h0070}); prod_en = 1'b0;
      check_frame("F2", P4, P3, P2, P1, 2, 24);
      offq.push_back({1'b0, 16'h0070}); prod_en = 1'b0;
      check_frame("F3", P0, P7, PB, PB, 2, 24);
      // Two back-to-back offers: the second stalls past the boundary.
      offq.push_back({1'b0, 16'h1111});
      offq.push_back({1'b0, 16'h2222}); prod_en = 1'b0;
      check_frame("F4", P0, P7, P0, P0, 3, 24);
      check_frame("F5", P1, P1, P1, P1, -1, 24);
      offq.push_back({1'b0, 16'hA0F9}); prod_en = 1'b0;
      check_frame("F6", P2, P2, P2, P2, 0, 24);
      offq.push_back({1'b1, 16'h0000}); prod_en = 1'b0;
      check_frame("F7", P9, PD, P0, PD, 5, 24);
      offq.push_back({1'b0, 16'h5678}); prod_en = 1'b0;
      check_frame("F8", P0, PB, PB, PB, 0, 24);
      offq.push_back({1'b0, 16'h9999}); prod_en = 1'b0;
      check_frame("F9", P8, P7, P6, P5, 1, 14);

      // One-cycle reset during digit2 ON with the buffer full and an offer live.
      reset    = 1'b1;
      in_valid = 1'b1;
      in_bcd   = 16'h4321;
      @(posedge clk); #1;
      reset    = 1'b0;
      in_valid = 1'b0;
      exp_pend = 1'b0;
      prod_en  = 1'b0;
      offq.delete();
      chk("midreset DIGIT", {12'h0, DIGIT}, 16'h000F);
      chk("midreset DISPLAY", {9'h0, DISPLAY}, 16'h007F);
      chk("midreset frame_done", {15'h0, frame_done}, 16'h0000);
      chk("midreset in_ready", {15'h0, in_ready}, 16'h0001);
      check_frame("F10", P0, P0, P0, P0, -1, 24);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter ON_CYC, default 100000: clock cycles each digit is driven, range 1..2^20-1.
REQ-002 Parameter BLANK_CYC, default 1000: clock cycles all digits are off between digits (anti-ghosting), range 1..2^16-1.
REQ-003 clk  input  1  system clock; all logic on rising edge, single clock domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  producer offers a new 4-digit BCD frame on in_bcd.
REQ-006 in_ready  output  1  controller can accept a frame; transfer occurs when in_valid && in_ready on a rising edge.
REQ-007 in_bcd  input  16  digit3 (leftmost) in [15:12] down to digit0 (rightmost) in [3:0].
REQ-008 lz_en  input  1  leading-zero suppression enable, captured with each accepted frame.
REQ-009 DIGIT  output  4  active-low anode enables; DIGIT[i] drives digit i.
REQ-010 DISPLAY  output  7  active-low segments; DISPLAY[0]=a ... DISPLAY[6]=g.
REQ-011 frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-012 The controller SHALL hold a pending register (value + lz flag + pend_full) and an active register (value + lz flag); in_ready SHALL equal !pend_full.
REQ-013 An accepted transfer SHALL set pend_full=1 and store in_bcd and lz_en; in_valid while in_ready=0 SHALL be ignored (no overwrite).
REQ-014 The scan FSM SHALL have states ON and BLANK plus a 2-bit digit index idx and a cycle counter.
REQ-015 ON: drive digit idx for ON_CYC cycles, then go to BLANK with counter cleared.
REQ-016 BLANK: all anodes off for BLANK_CYC cycles, then go to ON with idx+1 (3 wraps to 0).
REQ-017 Frame boundary = last BLANK cycle with idx==3; frame period SHALL be exactly 4*(ON_CYC+BLANK_CYC) cycles.
REQ-018 At a frame boundary with pend_full=1 the active register SHALL load from pending and pend_full SHALL clear in the same edge; active data SHALL never change mid-frame.
REQ-019 If in_valid arrives on the boundary cycle while pend_full=1, it SHALL NOT be accepted that cycle; in_ready rises the next cycle.
REQ-020 frame_done SHALL pulse high for the one cycle following every frame boundary, whether or not a load occurred.
REQ-021 Decode: nibble 0-9 SHALL map to standard active-low patterns (0=7'b1000000, 1=7'b1111001, 8=7'b0000000); 10-15 SHALL display dash (7'b0111111).
REQ-022 With active lz flag=1, digit k (k=3,2,1) SHALL be blanked (DISPLAY=7'b1111111, anode still cycled) when it and all higher digits are zero; digit0 SHALL never be suppressed.
REQ-023 DIGIT and DISPLAY SHALL be registered, reflecting FSM state/idx with exactly one cycle latency; in BLANK, DIGIT=4'b1111 and DISPLAY=7'b1111111.
REQ-024 In ON, exactly one DIGIT bit SHALL be low (bit idx).

Reset
REQ-025 On reset: state=ON, idx=0, counter=0, active value=16'h0000, active lz=0, pend_full=0, pending discarded.
REQ-026 Reset values: DIGIT=4'b1111, DISPLAY=7'b1111111, frame_done=0, in_ready=1 (from the first cycle after reset).
REQ-027 Reset asserted mid-frame or mid-handshake SHALL take effect at the next edge and abort the frame with no frame_done pulse.

Verification (ON_CYC=4, BLANK_CYC=2, 24-cycle frame)
REQ-028 Release reset, no input -> cycle 1: DIGIT=1110, DISPLAY=1000000 for 4 cycles; then 2 cycles 1111/1111111; then DIGIT=1101; frame_done pulses every 24 cycles.
REQ-029 Accept in_bcd=16'h1234, lz_en=0 mid-frame -> in_ready=0 until boundary; current frame still shows 0000; next frame shows digit0=4, digit1=3, digit2=2, digit3=1 (digit3 pattern 1111001).
REQ-030 in_bcd=16'h0070, lz_en=1 -> digits 3,2 blanked, digit1 shows 7, digit0 shows 0; with lz_en=0 all four shown.
REQ-031 Two back-to-back offers 16'h1111 then 16'h2222 within one frame -> second stalled (in_ready=0) until boundary; frame N+1 shows 1111, frame N+2 shows 2222.
REQ-032 in_bcd=16'hA0F9 -> digits 3 and 1 show dash 0111111, digit2 shows 0, digit0 shows 9.
REQ-033 Assert reset for 1 cycle during digit2 ON with pend_full=1 -> next cycle outputs at reset values, in_ready=1, following frame shows 0000.
